// File: rtl/fifo_frame_reader_pkg.sv
// rtl/fifo_frame_reader_pkg.sv - shared FSM encoding and counter width helper
package fifo_frame_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam int GAP_W = 8;

    // ceil(log2(n+1)): bits needed to hold values 0..n
    function automatic int cnt_width(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n + 1) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/ffr_skid_buf.sv
// rtl/ffr_skid_buf.sv - two-entry fall-through skid buffer
module ffr_skid_buf #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] mem [2];
    logic              rd_ptr;
    logic              wr_ptr;
    logic [1:0]        cnt;
    logic              push;
    logic              pop;

    assign count = cnt;

    // An empty buffer passes incoming data straight through; it is only stored when not taken
    always_comb begin
        in_ready  = (cnt != 2'd2);
        out_valid = (cnt != 2'd0) || in_valid;
        out_data  = '0;
        if (cnt != 2'd0) begin
            out_data = mem[rd_ptr];
        end else if (in_valid) begin
            out_data = in_data;
        end
        pop  = (cnt != 2'd0) && out_ready;
        push = in_valid && in_ready && !((cnt == 2'd0) && out_ready);
    end

    // Storage, pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/fifo_frame_reader.sv
// rtl/fifo_frame_reader.sv - reads fixed-length frames from a FIFO onto a valid/ready stream
module fifo_frame_reader
    import fifo_frame_reader_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int FRAME_LEN  = 256,
    parameter int GAP_CYCLES = 0
) (
    input  logic              rd_clk,
    input  logic              rd_rst_n,
    input  logic              enable,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_rd_data,
    input  logic              fifo_empty,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_first,
    output logic              m_last,
    output logic              busy,
    output logic [15:0]       frame_cnt
);

    localparam int               CW       = cnt_width(FRAME_LEN);
    localparam logic [CW-1:0]    LEN      = CW'(FRAME_LEN);
    localparam logic [CW-1:0]    LAST     = CW'(FRAME_LEN - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    issued;
    logic [CW-1:0]    out_cnt;
    logic             inflight;
    logic [GAP_W-1:0] gap_cnt;
    logic [15:0]      frame_cnt_q;
    logic [1:0]       buf_count;
    logic             skid_ready;
    logic             start;
    logic             xfer;
    logic             last_xfer;

    ffr_skid_buf #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk       (rd_clk),
        .rst_n     (rd_rst_n),
        .in_valid  (inflight),
        .in_data   (fifo_rd_data),
        .in_ready  (skid_ready),
        .out_valid (m_valid),
        .out_data  (m_data),
        .out_ready (m_ready),
        .count     (buf_count)
    );

    assign xfer      = m_valid && m_ready;
    assign last_xfer = xfer && (out_cnt == LAST);
    assign m_first   = m_valid && (out_cnt == '0);
    assign m_last    = m_valid && (out_cnt == LAST);
    assign busy      = (state != ST_IDLE);
    assign frame_cnt = frame_cnt_q;

    // Next state and read issue; a read is only issued if its word is guaranteed a buffer slot
    always_comb begin
        state_nxt  = state;
        fifo_rd_en = 1'b0;
        start      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable) begin
                    state_nxt = ST_RUN;
                    start     = 1'b1;
                end
            end
            ST_RUN: begin
                fifo_rd_en = !fifo_empty && (issued < LEN) && skid_ready &&
                             ((buf_count + {1'b0, inflight}) < 2'd2);
                if (last_xfer) begin
                    state_nxt = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Issue/output counters, in-flight flag, gap timer and completed-frame count
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            issued      <= '0;
            out_cnt     <= '0;
            inflight    <= 1'b0;
            gap_cnt     <= '0;
            frame_cnt_q <= '0;
        end else begin
            inflight <= fifo_rd_en;
            if (start) begin
                issued  <= '0;
                out_cnt <= '0;
            end else begin
                if (fifo_rd_en) issued  <= issued + 1'b1;
                if (xfer)       out_cnt <= out_cnt + 1'b1;
            end
            gap_cnt <= (state == ST_GAP) ? gap_cnt + 1'b1 : '0;
            if (last_xfer) frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

endmodule
